// File: rtl/mem_access_seq.sv
// Read/write sequencer driving the LC-3 MAR/MDR/RAM strobes through a req/busy/done handshake.
// Optional: define MEM_IO_GUARD_EN to reject writes into the 0xFE00-0xFFFF device page.
module mem_access_seq #(
    parameter int RD_LATENCY = 2,
    parameter int WR_CYCLES  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] rdata,
    output logic [15:0] bus_out,
    output logic        ldMAR,
    output logic        ldMDR,
    output logic        selMDR,
    output logic        memWE,
    input  logic [15:0] mdr_q
);

    typedef enum logic [6:0] {
        IDLE     = 7'b0000001,
        LD_MAR   = 7'b0000010,
        RD_WAIT  = 7'b0000100,
        LD_MDR_R = 7'b0001000,
        LD_MDR_W = 7'b0010000,
        WRITE    = 7'b0100000,
        DONE     = 7'b1000000
    } state_t;

    localparam logic [3:0] RD_LOAD = 4'(RD_LATENCY - 1);
    localparam logic [3:0] WR_LOAD = 4'(WR_CYCLES - 1);

    state_t      state_q;
    state_t      state_d;
    logic [15:0] addr_r;
    logic [15:0] wdata_r;
    logic        we_r;
    logic [3:0]  cnt_q;
    logic [3:0]  cnt_d;
    logic        memwe_q;
    logic        accept;
    logic        reject;

    assign accept = (state_q == IDLE) && req;

`ifdef MEM_IO_GUARD_EN
    logic rej_q;

    assign reject = we && (addr[15:9] == 7'h7F);
    assign err    = (state_q == DONE) && rej_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rej_q <= 1'b0;
        end else if (accept) begin
            rej_q <= reject;
        end
    end
`else
    assign reject = 1'b0;
    assign err    = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            memwe_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            memwe_q <= (state_d == WRITE);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_r  <= 16'h0000;
            wdata_r <= 16'h0000;
            we_r    <= 1'b0;
        end else if (accept) begin
            addr_r  <= addr;
            wdata_r <= wdata;
            we_r    <= we;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = reject ? DONE : LD_MAR;
                end
            end
            LD_MAR: begin
                if (we_r) begin
                    state_d = LD_MDR_W;
                end else begin
                    state_d = RD_WAIT;
                    cnt_d   = RD_LOAD;
                end
            end
            RD_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = LD_MDR_R;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            LD_MDR_R: state_d = DONE;
            LD_MDR_W: begin
                state_d = WRITE;
                cnt_d   = WR_LOAD;
            end
            WRITE: begin
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Moore decode; the bus keeps the address through the read and the data through the write
    always_comb begin
        bus_out = 16'h0000;
        ldMAR   = 1'b0;
        ldMDR   = 1'b0;
        selMDR  = 1'b0;
        unique case (state_q)
            LD_MAR: begin
                bus_out = addr_r;
                ldMAR   = 1'b1;
            end
            RD_WAIT:  bus_out = addr_r;
            LD_MDR_R: begin
                bus_out = addr_r;
                ldMDR   = 1'b1;
                selMDR  = 1'b1;
            end
            LD_MDR_W: begin
                bus_out = wdata_r;
                ldMDR   = 1'b1;
            end
            WRITE:   bus_out = wdata_r;
            default: bus_out = 16'h0000;
        endcase
    end

    assign busy  = (state_q != IDLE);
    assign done  = (state_q == DONE);
    assign memWE = memwe_q;
    assign rdata = mdr_q;

endmodule

// File: tb/tb_mem_access_seq.sv
// Bench for mem_access_seq: behavioural MAR/MDR/RAM block plus a scoreboard of written words.
// Latency and strobe timing are checked against the documented cycle schedule.
module tb_mem_access_seq;

    localparam int RDL = 2;
    localparam int WRC = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] rdata;
    logic [15:0] bus_out;
    logic        ldMAR;
    logic        ldMDR;
    logic        selMDR;
    logic        memWE;
    logic [15:0] mdr_q;

    logic [15:0] mar;
    logic [15:0] mdr;
    logic [15:0] ram [0:65535];

    int errors = 0;
    int checks = 0;

    logic [15:0] ref_mem [int];
    int          waddrs [$];

    typedef struct {
        int          idle_busy;
        int          done_cyc;
        int          ldmar_cyc;
        int          ldmdr_cyc;
        int          memwe_first;
        int          memwe_n;
        logic [15:0] bus_mar;
        logic [15:0] bus_mdr;
        logic        sel_mdr;
        logic        err;
        logic [15:0] rdata;
        int          bad;
    } obs_t;

    mem_access_seq #(
        .RD_LATENCY(RDL),
        .WR_CYCLES (WRC)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .we     (we),
        .addr   (addr),
        .wdata  (wdata),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .rdata  (rdata),
        .bus_out(bus_out),
        .ldMAR  (ldMAR),
        .ldMDR  (ldMDR),
        .selMDR (selMDR),
        .memWE  (memWE),
        .mdr_q  (mdr_q)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ldMAR) mar <= bus_out;
        if (ldMDR) mdr <= selMDR ? ram[mar] : bus_out;
        if (memWE) ram[mar] <= mdr;
    end
    assign mdr_q = mdr;

    task automatic run_access(input logic w, input logic [15:0] a, input logic [15:0] d,
                              input bit hold, input int pulse_at, output obs_t o);
        o.done_cyc    = -1;
        o.ldmar_cyc   = -1;
        o.ldmdr_cyc   = -1;
        o.memwe_first = -1;
        o.memwe_n     = 0;
        o.bus_mar     = 16'h0;
        o.bus_mdr     = 16'h0;
        o.sel_mdr     = 1'b0;
        o.err         = 1'b0;
        o.rdata       = 16'h0;
        o.bad         = 0;
        @(negedge clk);
        o.idle_busy = int'(busy);
        req   = 1'b1;
        we    = w;
        addr  = a;
        wdata = d;
        @(posedge clk);
        #1;
        req   = hold;
        we    = 1'($urandom);
        addr  = 16'($urandom);
        wdata = 16'($urandom);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (ldMAR && o.ldmar_cyc < 0) begin
                o.ldmar_cyc = c;
                o.bus_mar   = bus_out;
            end
            if (ldMDR && o.ldmdr_cyc < 0) begin
                o.ldmdr_cyc = c;
                o.bus_mdr   = bus_out;
                o.sel_mdr   = selMDR;
            end
            if (memWE) begin
                if (o.memwe_first < 0) o.memwe_first = c;
                o.memwe_n++;
            end
            if ((ldMAR && ldMDR) || (selMDR && !ldMDR) || !busy) o.bad++;
            if (done) begin
                o.done_cyc = c;
                o.err      = err;
                o.rdata    = rdata;
                break;
            end
            if (c == pulse_at) begin
                req   = 1'b1;
                we    = 1'b1;
                addr  = 16'h4000;
                wdata = 16'hA5A5;
            end
            if (c == pulse_at + 1) req = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #22;
        checks++;
        if ({busy, done, err, ldMAR, ldMDR, selMDR, memWE, bus_out} !== 23'd0) begin
            errors++;
            $display("FAIL reset_outputs got=%h exp=0",
                     {busy, done, err, ldMAR, ldMDR, selMDR, memWE, bus_out});
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle got busy=%0b exp=0", busy);
        end
    endtask

    task automatic test_write_basic();
        obs_t o;
        run_access(1'b1, 16'h3000, 16'hBEEF, 1'b0, -1, o);
        checks++;
        if (o.ldmar_cyc !== 1 || o.bus_mar !== 16'h3000) begin
            errors++;
            $display("FAIL wr_ldmar got cyc=%0d bus=%h exp cyc=1 bus=3000", o.ldmar_cyc, o.bus_mar);
        end
        checks++;
        if (o.ldmdr_cyc !== 2 || o.bus_mdr !== 16'hBEEF || o.sel_mdr !== 1'b0) begin
            errors++;
            $display("FAIL wr_ldmdr got cyc=%0d bus=%h sel=%0b exp cyc=2 bus=beef sel=0",
                     o.ldmdr_cyc, o.bus_mdr, o.sel_mdr);
        end
        checks++;
        if (o.memwe_first !== 3 || o.memwe_n !== WRC) begin
            errors++;
            $display("FAIL wr_memwe got first=%0d n=%0d exp first=3 n=%0d",
                     o.memwe_first, o.memwe_n, WRC);
        end
        checks++;
        if (o.done_cyc !== 3 + WRC || o.err !== 1'b0 || o.bad !== 0) begin
            errors++;
            $display("FAIL wr_done got cyc=%0d err=%0b bad=%0d exp cyc=%0d err=0 bad=0",
                     o.done_cyc, o.err, o.bad, 3 + WRC);
        end
        checks++;
        if (ram[16'h3000] !== 16'hBEEF) begin
            errors++;
            $display("FAIL wr_ram got=%h exp=beef", ram[16'h3000]);
        end
        ref_mem[16'h3000] = 16'hBEEF;
    endtask

    task automatic test_read_basic();
        obs_t o;
        run_access(1'b0, 16'h3000, 16'h0000, 1'b0, -1, o);
        checks++;
        if (o.ldmar_cyc !== 1 || o.bus_mar !== 16'h3000) begin
            errors++;
            $display("FAIL rd_ldmar got cyc=%0d bus=%h exp cyc=1 bus=3000", o.ldmar_cyc, o.bus_mar);
        end
        checks++;
        if (o.ldmdr_cyc !== 2 + RDL || o.sel_mdr !== 1'b1) begin
            errors++;
            $display("FAIL rd_ldmdr got cyc=%0d sel=%0b exp cyc=%0d sel=1",
                     o.ldmdr_cyc, o.sel_mdr, 2 + RDL);
        end
        checks++;
        if (o.memwe_n !== 0 || o.bad !== 0) begin
            errors++;
            $display("FAIL rd_strobes got memwe=%0d bad=%0d exp 0 0", o.memwe_n, o.bad);
        end
        checks++;
        if (o.done_cyc !== 3 + RDL || o.rdata !== 16'hBEEF) begin
            errors++;
            $display("FAIL rd_done got cyc=%0d data=%h exp cyc=%0d data=beef",
                     o.done_cyc, o.rdata, 3 + RDL);
        end
    endtask

    task automatic test_busy_ignore();
        obs_t o;
        int   extra;
        run_access(1'b0, 16'h3000, 16'h0000, 1'b0, 2, o);
        checks++;
        if (o.done_cyc !== 3 + RDL || o.rdata !== 16'hBEEF) begin
            errors++;
            $display("FAIL busy_first got cyc=%0d data=%h exp cyc=%0d data=beef",
                     o.done_cyc, o.rdata, 3 + RDL);
        end
        extra = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done || busy) extra++;
        end
        checks++;
        if (extra !== 0) begin
            errors++;
            $display("FAIL busy_ignored got extra=%0d exp=0", extra);
        end
        checks++;
        if (ram[16'h4000] === 16'hA5A5) begin
            errors++;
            $display("FAIL busy_ram got=%h exp!=a5a5", ram[16'h4000]);
        end
    endtask

    task automatic test_reset_mid_write();
        bit found;
        @(negedge clk);
        req   = 1'b1;
        we    = 1'b1;
        addr  = 16'h5000;
        wdata = 16'h5555;
        @(posedge clk);
        #1;
        req   = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (memWE) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL rstmid_reach got memWE=0 exp=1");
        end
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if ({memWE, busy, done, ldMAR, ldMDR} !== 5'd0) begin
            errors++;
            $display("FAIL rstmid_async got=%b exp=00000", {memWE, busy, done, ldMAR, ldMDR});
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || bus_out !== 16'h0000 || memWE !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_idle got busy=%0b bus=%h we=%0b exp 0 0000 0",
                     busy, bus_out, memWE);
        end
    endtask

    task automatic test_back_to_back();
        obs_t o1;
        obs_t o2;
        run_access(1'b1, 16'h3001, 16'h1234, 1'b1, -1, o1);
        run_access(1'b0, 16'h3001, 16'h0000, 1'b0, -1, o2);
        ref_mem[16'h3001] = 16'h1234;
        checks++;
        if (o1.done_cyc !== 3 + WRC) begin
            errors++;
            $display("FAIL b2b_wr got cyc=%0d exp=%0d", o1.done_cyc, 3 + WRC);
        end
        checks++;
        if (o2.idle_busy !== 0) begin
            errors++;
            $display("FAIL b2b_idle got busy=%0d exp=0", o2.idle_busy);
        end
        checks++;
        if (o2.done_cyc !== 3 + RDL || o2.rdata !== 16'h1234) begin
            errors++;
            $display("FAIL b2b_rd got cyc=%0d data=%h exp cyc=%0d data=1234",
                     o2.done_cyc, o2.rdata, 3 + RDL);
        end
    endtask

    task automatic test_guard();
        obs_t o;
        run_access(1'b1, 16'hFE02, 16'h7777, 1'b0, -1, o);
`ifdef MEM_IO_GUARD_EN
        checks++;
        if (o.done_cyc !== 1 || o.err !== 1'b1) begin
            errors++;
            $display("FAIL guard_rej got cyc=%0d err=%0b exp cyc=1 err=1", o.done_cyc, o.err);
        end
        checks++;
        if (o.ldmar_cyc !== -1 || o.ldmdr_cyc !== -1 || o.memwe_n !== 0) begin
            errors++;
            $display("FAIL guard_strobes got mar=%0d mdr=%0d we=%0d exp -1 -1 0",
                     o.ldmar_cyc, o.ldmdr_cyc, o.memwe_n);
        end
        checks++;
        if (ram[16'hFE02] === 16'h7777) begin
            errors++;
            $display("FAIL guard_ram got=%h exp!=7777", ram[16'hFE02]);
        end
`else
        checks++;
        if (o.done_cyc !== 3 + WRC || o.err !== 1'b0) begin
            errors++;
            $display("FAIL guard_off got cyc=%0d err=%0b exp cyc=%0d err=0",
                     o.done_cyc, o.err, 3 + WRC);
        end
        checks++;
        if (ram[16'hFE02] !== 16'h7777) begin
            errors++;
            $display("FAIL guard_off_ram got=%h exp=7777", ram[16'hFE02]);
        end
        ref_mem[16'hFE02] = 16'h7777;
`endif
        run_access(1'b0, 16'hFE02, 16'h0000, 1'b0, -1, o);
        checks++;
        if (o.done_cyc !== 3 + RDL || o.err !== 1'b0) begin
            errors++;
            $display("FAIL guard_rd got cyc=%0d err=%0b exp cyc=%0d err=0",
                     o.done_cyc, o.err, 3 + RDL);
        end
    endtask

    task automatic test_random();
        obs_t o;
        for (int i = 0; i < 40; i++) begin
            logic        w;
            logic [15:0] a;
            logic [15:0] d;
            bit          h;
            w = (waddrs.size() == 0) || ($urandom_range(0, 1) == 1);
            if (w) begin
                a = 16'($urandom_range(0, 4095));
                d = 16'($urandom);
            end else begin
                a = 16'(waddrs[$urandom_range(0, waddrs.size() - 1)]);
                d = 16'h0000;
            end
            h = (i != 39) && ($urandom_range(0, 1) == 1);
            run_access(w, a, d, h, -1, o);
            checks++;
            if (o.done_cyc !== (w ? 3 + WRC : 3 + RDL)) begin
                errors++;
                $display("FAIL rnd_lat[%0d] got=%0d exp=%0d", i, o.done_cyc,
                         w ? 3 + WRC : 3 + RDL);
            end
            checks++;
            if (o.bad !== 0 || o.err !== 1'b0 || o.idle_busy !== 0) begin
                errors++;
                $display("FAIL rnd_proto[%0d] got bad=%0d err=%0b idle_busy=%0d exp 0 0 0",
                         i, o.bad, o.err, o.idle_busy);
            end
            if (w) begin
                ref_mem[int'(a)] = d;
                waddrs.push_back(int'(a));
            end else begin
                checks++;
                if (o.rdata !== ref_mem[int'(a)]) begin
                    errors++;
                    $display("FAIL rnd_rdata[%0d] addr=%h got=%h exp=%h",
                             i, a, o.rdata, ref_mem[int'(a)]);
                end
            end
        end
        foreach (ref_mem[k]) begin
            checks++;
            if (ram[k] !== ref_mem[k]) begin
                errors++;
                $display("FAIL ram_final addr=%h got=%h exp=%h", k[15:0], ram[k], ref_mem[k]);
            end
        end
    endtask

    initial begin
        req   = 1'b0;
        we    = 1'b0;
        addr  = 16'h0000;
        wdata = 16'h0000;
        test_reset();
        test_write_basic();
        test_read_basic();
        test_busy_ignore();
        test_reset_mid_write();
        test_back_to_back();
        test_guard();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_access_seq.md
Name: mem_access_seq

Overview:
- Control sequencer directly upstream of the LC-3 Memory block (MAR/MDR/two-port RAM).
- Accepts single read or write requests from the LC-3 control FSM through a req/busy/done handshake.
- Drives the Memory block's bus value and its ldMAR, ldMDR, selMDR and memWE strobes in the correct cycle order.
- Returns read data taken from the Memory block's MDR output.

Parameters:
- RD_LATENCY, 2: wait cycles between MAR load and MDR capture; range 1-15.
- WR_CYCLES, 1: number of cycles memWE is held high per write; range 1-15.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  1  access request; sampled only in IDLE.
- we  in  1  1 = write, 0 = read; sampled with req.
- addr  in  16  word address; captured on accept.
- wdata  in  16  write data; captured on accept.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse that coincides with done on a rejected access (see Optional Feature).
- rdata  out  16  read data; valid while done=1 after a read.
- bus_out  out  16  value presented to the Memory block's Bus input.
- ldMAR  out  1  MAR load strobe.
- ldMDR  out  1  MDR load strobe.
- selMDR  out  1  MDR input mux select: 1 = RAM output, 0 = Bus.
- memWE  out  1  RAM write enable.
- mdr_q  in  16  MDROut from the Memory block.

Behaviour:
- Reset: asynchronous. State goes to IDLE; busy, done, err, ldMAR, ldMDR, selMDR and memWE go to 0; bus_out, the captured addr/wdata registers and the wait counter go to 0x0000.
- Reset mid-access: the access is abandoned and no strobe survives the reset assertion.
- Strobes are Moore outputs decoded from a one-hot state register. memWE comes from its own flop, so it cannot glitch.
- States:
  - IDLE: if req=1, capture addr, wdata and we, then go to LD_MAR. Otherwise stay.
  - LD_MAR: bus_out=addr_r, ldMAR=1. Go to LD_MDR_W if we_r=1, else RD_WAIT (counter loaded with RD_LATENCY-1).
  - RD_WAIT: all strobes 0, bus_out holds addr_r. Decrement the counter each cycle; leave to LD_MDR_R when the counter is 0. Total RD_LATENCY cycles.
  - LD_MDR_R: selMDR=1, ldMDR=1.
  - LD_MDR_W: bus_out=wdata_r, selMDR=0, ldMDR=1. Go to WRITE (counter loaded with WR_CYCLES-1).
  - WRITE: memWE=1, ldMAR=ldMDR=0, so MAR and MDR stay stable. Stay WR_CYCLES cycles.
  - DONE: done=1, busy=1. Always return to IDLE.
- Latency, counted in cycles after the accept edge:
  - Read: done is high in cycle 3+RD_LATENCY (5 at the default).
  - Write: done is high in cycle 3+WR_CYCLES (4 at the default).
- Handshake:
  - req while busy=1 is ignored, not queued.
  - req held high continuously yields back-to-back accesses. The next accept happens on the edge ending the cycle after DONE.
  - addr, wdata and we may change freely after the accept edge.
- rdata is wired to mdr_q. It is defined only while done=1 after a read, and stays stable until the next access loads MDR.
- selMDR is 0 in every state except LD_MDR_R. ldMAR and ldMDR are never high in the same cycle.
- memWE is high only in WRITE.

Optional Feature:
- Macro: MEM_IO_GUARD_EN.
- Defined:
  - A write with addr[15:9]=7'h7F (0xFE00-0xFFFF, the device-register page) is rejected.
  - Rejection path: IDLE goes directly to DONE. No ldMAR, ldMDR or memWE is issued. done=1 and err=1 in that cycle.
  - Reads of this page proceed normally.
- Not defined: err is tied to 0 and all writes are performed.

Test Plan:
- Write, addr=0x3000, wdata=0xBEEF, defaults → ldMAR in cycle 1 with bus_out=0x3000; ldMDR in cycle 2 with selMDR=0 and bus_out=0xBEEF; memWE in cycle 3; done in cycle 4; RAM[0x3000]=0xBEEF.
- Read of 0x3000 after that write, RD_LATENCY=2 → ldMAR in cycle 1; RD_WAIT in cycles 2-3; ldMDR with selMDR=1 in cycle 4; done in cycle 5 with rdata=0xBEEF.
- req pulsed while busy (second request with addr=0x4000) → ignored; only the first access completes; exactly one done pulse.
- reset asserted during WRITE with memWE=1 → memWE, busy and done drop to 0 immediately; after release the FSM sits in IDLE with bus_out=0x0000.
- req held high, alternating write 0x3001=0x1234 then read 0x3001 → back-to-back accesses with one IDLE cycle between them; read returns 0x1234.
- Guard build, MEM_IO_GUARD_EN defined: write to 0xFE02 → done=err=1 in cycle 1; no strobes issued; RAM unchanged. Without the macro the same write completes in 4 cycles with err=0.
